// File: rtl/led_pkg.sv
// Shared definitions for the LED scan controller: scan state encoding and the
// active-low hex glyph table, bit order {g,f,e,d,c,b,a}.
package led_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_DRIVE = 2'd2
  } scan_state_e;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Entry 0 is the rightmost element: glyphs for F,E,d,C,b,A,9,8,7,6,5,4,3,2,1,0.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex nibble to active-low 7-segment pattern lookup.
module hex_to_7seg
  import led_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);

  assign seg_n = SEG_TABLE[nibble];

endmodule

// File: rtl/led_scan_ctrl.sv
// Multiplexed 7-segment scan controller with blank gap, 16-level PWM and a
// double-buffered display image that only changes at frame boundaries.
module led_scan_ctrl
  import led_pkg::*;
#(
  parameter int FPGA_CLK     = 100_000_000,
  parameter int SCAN_HZ      = 1_000,
  parameter int NUM_DIGITS   = 4,
  parameter int BLANK_CYCLES = 100
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [3:0]              brightness,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic [6:0]              seg_n,
  output logic                    dp_n,
  output logic                    frame_done
);

  localparam int DWELL_CYC = FPGA_CLK / SCAN_HZ;
  localparam int DRIVE_CYC = DWELL_CYC - BLANK_CYCLES;
  localparam int CNT_W     = $clog2(DWELL_CYC + 1);
  localparam int IDX_W     = $clog2(NUM_DIGITS);
  localparam int PW        = CNT_W + 5;

  scan_state_e state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d, on_cyc_q, on_cyc_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] digits_sh_q, digits_sh_d, stg_digits_q, stg_digits_d;
  logic [NUM_DIGITS-1:0]   dp_sh_q, dp_sh_d, stg_dp_q, stg_dp_d;
  logic [NUM_DIGITS-1:0]   den_sh_q, den_sh_d, stg_den_q, stg_den_d;
  logic [3:0]              bright_sh_q, bright_sh_d, stg_bright_q, stg_bright_d;
  logic                    pending_q, pending_d;
  logic [NUM_DIGITS-1:0]   an_n_q, an_n_d;
  logic [6:0]              seg_n_q, seg_n_d;
  logic                    dp_n_q, dp_n_d;
  logic                    frame_done_q, frame_done_d;
  logic                    wrap, frame_start;
  logic [PW-1:0]           on_prod;
  logic [3:0]              cur_nibble;
  logic [6:0]              cur_seg;

  assign on_prod    = (PW'(bright_sh_d) + PW'(1)) * PW'(DRIVE_CYC);
  assign cur_nibble = digits_sh_d[{idx_d, 2'b00} +: 4];

  hex_to_7seg u_dec (
    .nibble (cur_nibble),
    .seg_n  (cur_seg)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    on_cyc_d     = on_cyc_q;
    wrap         = 1'b0;
    frame_start  = 1'b0;
    if (!en) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d     = ST_BLANK;
          cnt_d       = '0;
          idx_d       = '0;
          frame_start = 1'b1;
        end
        ST_BLANK: begin
          if (cnt_q == CNT_W'(BLANK_CYCLES - 1)) begin
            state_d = ST_DRIVE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_DRIVE: begin
          if (cnt_q == CNT_W'(DRIVE_CYC - 1)) begin
            state_d = ST_BLANK;
            cnt_d   = '0;
            if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
              idx_d       = '0;
              wrap        = 1'b1;
              frame_start = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Shadow only changes while idle or exactly at the frame wrap; otherwise stage.
    digits_sh_d  = digits_sh_q;
    dp_sh_d      = dp_sh_q;
    den_sh_d     = den_sh_q;
    bright_sh_d  = bright_sh_q;
    stg_digits_d = stg_digits_q;
    stg_dp_d     = stg_dp_q;
    stg_den_d    = stg_den_q;
    stg_bright_d = stg_bright_q;
    pending_d    = pending_q;
    if ((state_q == ST_IDLE || wrap) && load) begin
      digits_sh_d = digits_in;
      dp_sh_d     = dp_in;
      den_sh_d    = digit_en;
      bright_sh_d = brightness;
      pending_d   = 1'b0;
    end else if (wrap && pending_q) begin
      digits_sh_d = stg_digits_q;
      dp_sh_d     = stg_dp_q;
      den_sh_d    = stg_den_q;
      bright_sh_d = stg_bright_q;
      pending_d   = 1'b0;
    end else if (load) begin
      stg_digits_d = digits_in;
      stg_dp_d     = dp_in;
      stg_den_d    = digit_en;
      stg_bright_d = brightness;
      pending_d    = 1'b1;
    end

    if (frame_start) on_cyc_d = CNT_W'(on_prod >> 4);

    // Outputs are registered from next-state values so they line up with the state.
    frame_done_d = wrap;
    an_n_d       = '1;
    seg_n_d      = SEG_OFF;
    dp_n_d       = 1'b1;
    if (state_d != ST_IDLE) begin
      seg_n_d = cur_seg;
      dp_n_d  = ~dp_sh_d[idx_d];
      if (state_d == ST_DRIVE && cnt_d < on_cyc_d && den_sh_d[idx_d])
        an_n_d = ~(NUM_DIGITS'(1) << idx_d);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      on_cyc_q     <= '0;
      digits_sh_q  <= '0;
      dp_sh_q      <= '0;
      den_sh_q     <= '0;
      bright_sh_q  <= '0;
      pending_q    <= 1'b0;
      an_n_q       <= '1;
      seg_n_q      <= SEG_OFF;
      dp_n_q       <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      on_cyc_q     <= on_cyc_d;
      digits_sh_q  <= digits_sh_d;
      dp_sh_q      <= dp_sh_d;
      den_sh_q     <= den_sh_d;
      bright_sh_q  <= bright_sh_d;
      pending_q    <= pending_d;
      an_n_q       <= an_n_d;
      seg_n_q      <= seg_n_d;
      dp_n_q       <= dp_n_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Staging contents are only consumed when pending_q is set, so they need no reset.
  always_ff @(posedge clk) begin
    stg_digits_q <= stg_digits_d;
    stg_dp_q     <= stg_dp_d;
    stg_den_q    <= stg_den_d;
    stg_bright_q <= stg_bright_d;
  end

  assign an_n       = an_n_q;
  assign seg_n      = seg_n_q;
  assign dp_n       = dp_n_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Directed self-checking bench for led_scan_ctrl with a 10-cycle dwell
// (2 blank + 8 drive) across 4 digits.
module tb_led_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst, en, load;
  logic [15:0] digits_in;
  logic [3:0]  dp_in, digit_en, brightness;
  logic [3:0]  an_n;
  logic [6:0]  seg_n;
  logic        dp_n, frame_done;

  int checks   = 0;
  int failures = 0;

  led_scan_ctrl #(
    .FPGA_CLK     (100),
    .SCAN_HZ      (10),
    .NUM_DIGITS   (4),
    .BLANK_CYCLES (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .load       (load),
    .digits_in  (digits_in),
    .dp_in      (dp_in),
    .digit_en   (digit_en),
    .brightness (brightness),
    .an_n       (an_n),
    .seg_n      (seg_n),
    .dp_n       (dp_n),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'h0: glyph = 7'b1000000; 4'h1: glyph = 7'b1111001;
      4'h2: glyph = 7'b0100100; 4'h3: glyph = 7'b0110000;
      4'h4: glyph = 7'b0011001; 4'h5: glyph = 7'b0010010;
      4'h6: glyph = 7'b0000010; 4'h7: glyph = 7'b1111000;
      4'h8: glyph = 7'b0000000; 4'h9: glyph = 7'b0010000;
      4'hA: glyph = 7'b0001000; 4'hB: glyph = 7'b0000011;
      4'hC: glyph = 7'b1000110; 4'hD: glyph = 7'b0100001;
      4'hE: glyph = 7'b0000110; default: glyph = 7'b0001110;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the DUT on the first BLANK cycle (scan cycle 0) of a fresh frame.
  task automatic start_scan(input logic [15:0] d, input logic [3:0] dp,
                            input logic [3:0] de, input logic [3:0] br);
    en = 1'b0; load = 1'b0;
    tick();
    digits_in = d; dp_in = dp; digit_en = de; brightness = br; load = 1'b1;
    tick();
    load = 1'b0; en = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; load = 1'b0;
    digits_in = '0; dp_in = '0; digit_en = '0; brightness = '0;
    tick(); tick();
    checks++; if (an_n !== 4'hF) begin failures++; $display("FAIL reset_an_n got=%h exp=f", an_n); end
    checks++; if (seg_n !== 7'h7F) begin failures++; $display("FAIL reset_seg_n got=%h exp=7f", seg_n); end
    checks++; if (dp_n !== 1'b1) begin failures++; $display("FAIL reset_dp_n got=%b exp=1", dp_n); end
    checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_frame_done got=%b exp=0", frame_done); end
    rst = 1'b0;
  endtask

  task automatic test_scan();
    logic [15:0] d;
    logic [3:0]  exp_an;
    int idx;
    d = 16'h3210;
    start_scan(d, 4'b0010, 4'hF, 4'd15);
    for (int c = 0; c <= 40; c++) begin
      idx = (c % 40) / 10;
      exp_an = ((c % 10) < 2) ? 4'hF : ~(4'b0001 << idx);
      checks++; if (an_n !== exp_an) begin failures++; $display("FAIL scan_an_n c=%0d got=%h exp=%h", c, an_n, exp_an); end
      checks++; if (seg_n !== glyph(d[idx*4 +: 4])) begin failures++; $display("FAIL scan_seg_n c=%0d got=%h exp=%h", c, seg_n, glyph(d[idx*4 +: 4])); end
      checks++; if (dp_n !== (idx != 1)) begin failures++; $display("FAIL scan_dp_n c=%0d got=%b exp=%b", c, dp_n, idx != 1); end
      checks++; if (frame_done !== (c == 40)) begin failures++; $display("FAIL scan_frame_done c=%0d got=%b exp=%b", c, frame_done, c == 40); end
      tick();
    end
  endtask

  task automatic test_brightness();
    logic [3:0] br_tab [4] = '{4'd7, 4'd15, 4'd0, 4'd3};
    int         on_tab [4] = '{4, 8, 0, 2};
    int lows;
    for (int k = 0; k < 4; k++) begin
      start_scan(16'h3210, 4'h0, 4'hF, br_tab[k]);
      lows = 0;
      for (int c = 0; c < 10; c++) begin
        if (an_n[0] === 1'b0) lows++;
        tick();
      end
      checks++;
      if (lows !== on_tab[k]) begin
        failures++;
        $display("FAIL brightness_%0d on_cycles got=%0d exp=%0d", br_tab[k], lows, on_tab[k]);
      end
    end
  endtask

  task automatic test_tear_free();
    logic [15:0] cur;
    int idx;
    start_scan(16'h3210, 4'h0, 4'hF, 4'd15);
    for (int c = 0; c <= 80; c++) begin
      cur = (c < 40) ? 16'h3210 : (c < 80) ? 16'h8765 : 16'h000F;
      idx = (c % 40) / 10;
      checks++; if (seg_n !== glyph(cur[idx*4 +: 4])) begin failures++; $display("FAIL tear_seg_n c=%0d got=%h exp=%h", c, seg_n, glyph(cur[idx*4 +: 4])); end
      checks++; if (frame_done !== (c == 40 || c == 80)) begin failures++; $display("FAIL tear_frame_done c=%0d got=%b", c, frame_done); end
      if (c == 12 || c == 15 || c == 79) begin
        digits_in = (c == 12) ? 16'hAAAA : (c == 15) ? 16'h8765 : 16'h000F;
        load = 1'b1;
        tick();
        load = 1'b0;
      end else begin
        tick();
      end
    end
  endtask

  task automatic test_digit_en();
    int low0, low2;
    start_scan(16'h3210, 4'h0, 4'b0101, 4'd15);
    low0 = 0; low2 = 0;
    for (int c = 0; c <= 40; c++) begin
      if (c < 40) begin
        checks++;
        if (an_n[1] !== 1'b1 || an_n[3] !== 1'b1) begin
          failures++; $display("FAIL den_disabled_lit c=%0d an_n=%h", c, an_n);
        end
      end
      if (an_n[0] === 1'b0) low0++;
      if (an_n[2] === 1'b0) low2++;
      if (c >= 1) begin
        checks++;
        if (frame_done !== (c == 40)) begin
          failures++; $display("FAIL den_frame_len c=%0d got=%b exp=%b", c, frame_done, c == 40);
        end
      end
      tick();
    end
    checks++; if (low0 !== 8) begin failures++; $display("FAIL den_digit0_on got=%0d exp=8", low0); end
    checks++; if (low2 !== 8) begin failures++; $display("FAIL den_digit2_on got=%0d exp=8", low2); end
  endtask

  task automatic test_en_drop();
    start_scan(16'h3210, 4'h0, 4'hF, 4'd15);
    repeat (25) tick();
    checks++; if (an_n !== 4'b1011) begin failures++; $display("FAIL endrop_pre_an_n got=%h exp=b", an_n); end
    en = 1'b0;
    tick();
    checks++; if (an_n !== 4'hF) begin failures++; $display("FAIL endrop_an_n got=%h exp=f", an_n); end
    checks++; if (seg_n !== 7'h7F) begin failures++; $display("FAIL endrop_seg_n got=%h exp=7f", seg_n); end
    checks++; if (dp_n !== 1'b1) begin failures++; $display("FAIL endrop_dp_n got=%b exp=1", dp_n); end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (frame_done !== 1'b0 || an_n !== 4'hF) begin
        failures++; $display("FAIL endrop_idle k=%0d fd=%b an_n=%h", k, frame_done, an_n);
      end
      tick();
    end
    en = 1'b1;
    tick();
    checks++; if (an_n !== 4'hF) begin failures++; $display("FAIL reen_blank_an_n got=%h exp=f", an_n); end
    checks++; if (seg_n !== glyph(4'h0)) begin failures++; $display("FAIL reen_seg_n got=%h exp=%h", seg_n, glyph(4'h0)); end
    tick(); tick();
    checks++; if (an_n !== 4'b1110) begin failures++; $display("FAIL reen_digit0_an_n got=%h exp=e", an_n); end
  endtask

  task automatic test_rst_mid();
    start_scan(16'h8765, 4'hF, 4'hF, 4'd15);
    repeat (23) tick();
    rst = 1'b1;
    tick();
    checks++; if (an_n !== 4'hF) begin failures++; $display("FAIL rstmid_an_n got=%h exp=f", an_n); end
    checks++; if (seg_n !== 7'h7F) begin failures++; $display("FAIL rstmid_seg_n got=%h exp=7f", seg_n); end
    checks++; if (dp_n !== 1'b1) begin failures++; $display("FAIL rstmid_dp_n got=%b exp=1", dp_n); end
    checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL rstmid_frame_done got=%b exp=0", frame_done); end
    rst = 1'b0;
    tick();
    for (int c = 0; c < 40; c++) begin
      if (c % 10 == 0) begin
        checks++;
        if (seg_n !== glyph(4'h0)) begin failures++; $display("FAIL rstmid_shadow_seg c=%0d got=%h exp=%h", c, seg_n, glyph(4'h0)); end
      end
      checks++;
      if (an_n !== 4'hF || dp_n !== 1'b1) begin
        failures++; $display("FAIL rstmid_shadow_dark c=%0d an_n=%h dp_n=%b exp=f/1", c, an_n, dp_n);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_brightness();
    test_tear_free();
    test_digit_en();
    test_en_drop();
    test_rst_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
